// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep sequencer.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        TT_IDLE,
        TT_DRIVE,
        TT_SAMPLE,
        TT_DONE
    } tt_state_t;

    localparam int SETTLE_W = 4;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_popcount.sv
// Combinational population count of a W-bit vector.
module tt_popcount #(
    parameter int W = 16
) (
    input  logic [W-1:0]       bits,
    output logic [$clog2(W):0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + {{$clog2(W){1'b0}}, bits[i]};
        end
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// Drives every input vector of a combinational circuit in ascending order,
// samples its output into a truth table and compares it with a reference.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [tt_width(N_IN)-1:0]   expected,
    output logic [N_IN-1:0]             x,
    input  logic                        f1,
    output logic                        busy,
    output logic                        tt_valid,
    input  logic                        tt_ready,
    output logic [tt_width(N_IN)-1:0]   truth_table,
    output logic                        match,
    output logic [N_IN:0]               mismatches
);

    localparam int TW = tt_width(N_IN);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]     IDX_LAST    = '1;

    tt_state_t           state;
    logic [N_IN-1:0]     idx;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [TW-1:0]       exp_q;
    logic [TW-1:0]       tt_final;
    logic [TW-1:0]       diff;
    logic [N_IN:0]       pop;

    // Table as it will look after this cycle's sample; used so match and
    // mismatches are ready on the same edge that enters DONE.
    always_comb begin
        tt_final      = truth_table;
        tt_final[idx] = f1;
    end

    assign diff = tt_final ^ exp_q;

    tt_popcount #(.W(TW)) u_popcount (
        .bits  (diff),
        .count (pop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= TT_IDLE;
            idx         <= '0;
            settle_cnt  <= '0;
            exp_q       <= '0;
            x           <= '0;
            busy        <= 1'b0;
            tt_valid    <= 1'b0;
            truth_table <= '0;
            match       <= 1'b0;
            mismatches  <= '0;
        end else begin
            case (state)
                TT_IDLE: begin
                    if (start) begin
                        exp_q       <= expected;
                        truth_table <= '0;
                        idx         <= '0;
                        settle_cnt  <= '0;
                        x           <= '0;
                        busy        <= 1'b1;
                        state       <= TT_DRIVE;
                    end
                end
                TT_DRIVE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= TT_SAMPLE;
                    end
                end
                TT_SAMPLE: begin
                    truth_table <= tt_final;
                    if (idx == IDX_LAST) begin
                        x          <= '0;
                        busy       <= 1'b0;
                        tt_valid   <= 1'b1;
                        match      <= (tt_final == exp_q);
                        mismatches <= pop;
                        state      <= TT_DONE;
                    end else begin
                        idx        <= idx + 1'b1;
                        x          <= idx + 1'b1;
                        settle_cnt <= '0;
                        state      <= TT_DRIVE;
                    end
                end
                TT_DONE: begin
                    if (tt_ready) begin
                        tt_valid <= 1'b0;
                        state    <= TT_IDLE;
                    end
                end
                default: state <= TT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Self-checking bench: two instances (settle 1 and 3) around a NAND model.
module tb_tt_sweep_capture;

    logic        clk = 1'b0;
    logic        rst;

    logic        start0, busy0, vld0, rdy0, match0, f1_0;
    logic [15:0] exp0, tt0;
    logic [3:0]  x0v;
    logic [4:0]  mism0;

    logic        start1, busy1, vld1, rdy1, match1, f1_1;
    logic [15:0] exp1, tt1;
    logic [3:0]  x1v;
    logic [4:0]  mism1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] tt;
        logic        m;
        logic [4:0]  mm;
    } res_t;

    typedef struct {
        logic [15:0] e;
        logic [15:0] tt;
        logic        m;
        logic [4:0]  mm;
    } vec_t;

    res_t sb0[$];
    res_t sb1[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    // Circuit under characterisation: f1 = ~(x1 & x2)
    assign f1_0 = ~(x0v[1] & x0v[2]);
    assign f1_1 = ~(x1v[1] & x1v[2]);

    tt_sweep_capture #(.N_IN(4), .SETTLE(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .expected(exp0), .x(x0v),
        .f1(f1_0), .busy(busy0), .tt_valid(vld0), .tt_ready(rdy0),
        .truth_table(tt0), .match(match0), .mismatches(mism0)
    );

    tt_sweep_capture #(.N_IN(4), .SETTLE(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .expected(exp1), .x(x1v),
        .f1(f1_1), .busy(busy1), .tt_valid(vld1), .tt_ready(rdy1),
        .truth_table(tt1), .match(match1), .mismatches(mism1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic compare0(input string tag);
        res_t r;
        if (sb0.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            r = sb0.pop_front();
            check({tag, "_tt"}, 32'(tt0), 32'(r.tt));
            check({tag, "_match"}, 32'(match0), 32'(r.m));
            check({tag, "_mism"}, 32'(mism0), 32'(r.mm));
        end
    endtask

    // Full sweep on the SETTLE=1 instance with tt_ready held high.
    task automatic sweep0(input vec_t v, input string tag);
        int cyc;
        int xerr;
        res_t r;
        start0 = 1'b1;
        exp0   = v.e;
        r.tt = v.tt; r.m = v.m; r.mm = v.mm;
        sb0.push_back(r);
        @(negedge clk);
        start0 = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy0), 32'd1);
        cyc = 0;
        xerr = 0;
        while (!vld0 && cyc < 200) begin
            if (x0v !== 4'(cyc / 2)) xerr++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd32);
        check({tag, "_x_steps"}, 32'(xerr), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy0), 32'd0);
        compare0(tag);
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(vld0), 32'd0);
    endtask

    initial begin
        int cyc;
        int bad;
        res_t r;

        vecs[0] = '{16'h3F3F, 16'h3F3F, 1'b1, 5'd0};
        vecs[1] = '{16'h3F3E, 16'h3F3F, 1'b0, 5'd1};
        vecs[2] = '{16'h0000, 16'h3F3F, 1'b0, 5'd12};
        vecs[3] = '{16'hFFFF, 16'h3F3F, 1'b0, 5'd4};
        vecs[4] = '{16'hC0C0, 16'h3F3F, 1'b0, 5'd16};

        rst = 1'b1;
        start0 = 1'b0; exp0 = '0; rdy0 = 1'b1;
        start1 = 1'b0; exp1 = '0; rdy1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_x", 32'(x0v), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_valid", 32'(vld0), 32'd0);
        check("rst_tt", 32'(tt0), 32'd0);
        check("rst_match", 32'(match0), 32'd0);
        check("rst_mism", 32'(mism0), 32'd0);
        check("rst_valid1", 32'(vld1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            sweep0(vecs[i], $sformatf("vec%0d", i));
        end

        // SETTLE=3 with 10 cycles of backpressure
        start1 = 1'b1;
        exp1   = 16'h3F3F;
        r.tt = 16'h3F3F; r.m = 1'b1; r.mm = 5'd0;
        sb1.push_back(r);
        @(negedge clk);
        start1 = 1'b0;
        check("s3_busy_rise", 32'(busy1), 32'd1);
        cyc = 0;
        bad = 0;
        while (!vld1 && cyc < 300) begin
            if (x1v !== 4'(cyc / 4)) bad++;
            @(negedge clk);
            cyc++;
        end
        check("s3_latency", 32'(cyc), 32'd64);
        check("s3_x_steps", 32'(bad), 32'd0);
        r = sb1.pop_front();
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (!vld1 || tt1 !== r.tt || match1 !== r.m || mism1 !== r.mm || busy1 || x1v !== 4'd0)
                bad++;
            @(negedge clk);
        end
        check("s3_hold_stable", 32'(bad), 32'd0);
        check("s3_still_valid", 32'(vld1), 32'd1);
        rdy1 = 1'b1;
        @(negedge clk);
        check("s3_handshake", 32'(vld1), 32'd0);
        rdy1 = 1'b0;

        // Ignored starts: mid-sweep and on the handshake cycle
        start0 = 1'b1;
        exp0   = 16'h3F3F;
        r.tt = 16'h3F3F; r.m = 1'b1; r.mm = 5'd0;
        sb0.push_back(r);
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        while (!vld0 && cyc < 200) begin
            start0 = (cyc == 5);
            exp0   = (cyc == 5) ? 16'h0000 : 16'h3F3F;
            @(negedge clk);
            cyc++;
        end
        start0 = 1'b0;
        check("ign_latency", 32'(cyc), 32'd32);
        compare0("ign");
        start0 = 1'b1;
        exp0   = 16'h0000;
        @(negedge clk);
        start0 = 1'b0;
        check("ign_valid_drop", 32'(vld0), 32'd0);
        check("ign_busy", 32'(busy0), 32'd0);
        check("ign_x", 32'(x0v), 32'd0);
        bad = 0;
        repeat (40) begin
            if (busy0 || vld0) bad++;
            @(negedge clk);
        end
        check("ign_no_second", 32'(bad), 32'd0);

        // Reset at vector 7
        start0 = 1'b1;
        exp0   = 16'h3F3F;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        while (x0v !== 4'd7 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reach7", 32'(x0v), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_x", 32'(x0v), 32'd0);
        check("mid_busy", 32'(busy0), 32'd0);
        check("mid_valid", 32'(vld0), 32'd0);
        check("mid_tt", 32'(tt0), 32'd0);
        sweep0(vecs[1], "post_rst");

        // Reset while in DONE
        rdy0   = 1'b0;
        start0 = 1'b1;
        exp0   = 16'h3F3F;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        while (!vld0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("done_rst_reach", 32'(vld0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        rdy0 = 1'b1;
        check("done_rst_valid", 32'(vld0), 32'd0);
        bad = 0;
        repeat (5) begin
            if (vld0 || busy0) bad++;
            @(negedge clk);
        end
        check("done_rst_quiet", 32'(bad), 32'd0);

        check("sb0_drained", 32'(sb0.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
